// File: rtl/edge_event_scheduler.sv
// Per-channel 4-state edge detector feeding small event FIFOs, drained through a
// round-robin arbiter into a single registered output slot.
module edge_event_scheduler #(
    parameter int NCH   = 4,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [2*NCH-1:0]       sig,
    output logic                   ev_valid,
    input  logic                   ev_ready,
    output logic [$clog2(NCH)-1:0] ev_chan,
    output logic                   ev_neg,
    output logic [NCH-1:0]         ovf,
    input  logic [NCH-1:0]         ovf_clr
);
    localparam int CW = $clog2(NCH);
    localparam int AW = $clog2(DEPTH);

    logic [2*NCH-1:0] prev;
    logic [DEPTH-1:0] mem [NCH];
    logic [AW-1:0]    rd_ptr [NCH];
    logic [AW-1:0]    wr_ptr [NCH];
    logic [AW:0]      count [NCH];
    logic [CW-1:0]    rr;

    logic [NCH-1:0] det, det_neg, nonempty, full, req, head;
    logic [NCH-1:0] pop, do_pop, do_push, ovf_set;
    logic [CW-1:0]  cand, gnt;
    logic           gnt_found, slot_free, load;

    // Encoding: 00=0, 01=1, 10=z, 11=x; bit 1 set means an unknown level.
    always_comb begin
        det     = '0;
        det_neg = '0;
        for (int i = 0; i < NCH; i++) begin
            det_neg[i] = en && ((prev[2*i +: 2] == 2'b01 && sig[2*i +: 2] != 2'b01) ||
                                (prev[2*i+1] && sig[2*i +: 2] == 2'b00));
            det[i]     = det_neg[i] ||
                         (en && ((prev[2*i +: 2] == 2'b00 && sig[2*i +: 2] != 2'b00) ||
                                 (prev[2*i+1] && sig[2*i +: 2] == 2'b01)));
        end
    end

    // An edge arriving at an empty FIFO competes directly, giving 1-cycle latency.
    always_comb begin
        nonempty = '0;
        full     = '0;
        req      = '0;
        head     = '0;
        for (int i = 0; i < NCH; i++) begin
            nonempty[i] = (count[i] != '0);
            full[i]     = (count[i] == (AW+1)'(DEPTH));
            req[i]      = nonempty[i] || det[i];
            head[i]     = nonempty[i] ? mem[i][rd_ptr[i]] : det_neg[i];
        end
    end

    always_comb begin
        cand      = rr;
        gnt       = '0;
        gnt_found = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            cand = (cand == CW'(NCH-1)) ? '0 : cand + CW'(1);
            if (!gnt_found && req[cand]) begin
                gnt_found = 1'b1;
                gnt       = cand;
            end
        end
        slot_free = !ev_valid || ev_ready;
        load      = slot_free && gnt_found;
        pop       = '0;
        do_pop    = '0;
        do_push   = '0;
        ovf_set   = '0;
        for (int i = 0; i < NCH; i++) begin
            pop[i]     = load && (gnt == CW'(i));
            do_pop[i]  = pop[i] && nonempty[i];
            do_push[i] = det[i] && !(pop[i] && !nonempty[i]) && (!full[i] || do_pop[i]);
            ovf_set[i] = det[i] && full[i] && !do_pop[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev     <= '1;
            rr       <= CW'(NCH-1);
            ev_valid <= 1'b0;
            ev_chan  <= '0;
            ev_neg   <= 1'b0;
            ovf      <= '0;
            for (int i = 0; i < NCH; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            if (en) prev <= sig;
            ovf <= (ovf & ~ovf_clr) | ovf_set;
            for (int i = 0; i < NCH; i++) begin
                if (do_pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
                if (do_push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
                count[i] <= count[i] + (AW+1)'(do_push[i]) - (AW+1)'(do_pop[i]);
            end
            if (load) begin
                rr       <= gnt;
                ev_valid <= 1'b1;
                ev_chan  <= gnt;
                ev_neg   <= head[gnt];
            end else if (slot_free) begin
                ev_valid <= 1'b0;
            end
        end
    end

    // Storage is left unreset; occupancy is tracked solely by the pointers and counts.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (do_push[i]) mem[i][wr_ptr[i]] <= det_neg[i];
        end
    end
endmodule

// File: doc/edge_event_scheduler.md
EDGE_EVENT_SCHEDULER -- requirements
Module: edge_event_scheduler

Interface
REQ-001 The block SHALL have parameter NCH, default 4, giving the number of monitored channels (2..8).
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the per-channel event FIFO depth (power of two, >= 2).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port en, input, 1, which enables edge detection when high.
REQ-006 The block SHALL have port sig, input, 2*NCH, holding the 4-state value per channel; channel i is in bits [2i+1:2i], encoded 00=0, 01=1, 10=z, 11=x.
REQ-007 The block SHALL have port ev_valid, output, 1, which flags an event presented to the consumer.
REQ-008 The block SHALL have port ev_ready, input, 1, the consumer accept signal.
REQ-009 The block SHALL have port ev_chan, output, clog2(NCH), giving the channel of the presented event.
REQ-010 The block SHALL have port ev_neg, output, 1, giving the presented event kind: 0 = posedge, 1 = negedge.
REQ-011 The block SHALL have port ovf, output, NCH, holding per-channel sticky overflow flags.
REQ-012 The block SHALL have port ovf_clr, input, NCH, which clears the corresponding ovf bits, one bit per channel.

Function
REQ-013 Each channel SHALL keep a prev register, and SHALL compare sig against prev every cycle that en=1.
- prev updates to sig each cycle en=1.
- prev holds while en=0.
REQ-014 Posedge SHALL be detected on these transitions: 0->1, 0->x, 0->z, x->1, z->1.
REQ-015 Negedge SHALL be detected on these transitions: 1->0, 1->x, 1->z, x->0, z->0.
REQ-016 The transitions x<->z and any unchanged value SHALL generate no event.
REQ-017 A detected edge SHALL be pushed into that channel's FIFO (1-bit kind) at the end of the detecting cycle, preserving per-channel order.
REQ-018 FIFO full with no pop in the same cycle:
- new edge dropped;
- ovf[i] set.
FIFO full with a pop in the same cycle: the push SHALL be accepted, with no overflow.
REQ-019 ovf_clr[i] and a new overflow on the same channel in the same cycle SHALL leave ovf[i]=1 (set wins).
REQ-020 Output stage: a single registered slot carrying ev_valid, ev_chan and ev_neg.
- ev_chan and ev_neg SHALL stay stable while ev_valid=1 and ev_ready=0.
REQ-021 The slot SHALL load when it is empty or consumed (ev_valid & ev_ready); a load pops the head of the granted channel's FIFO.
REQ-022 Grant SHALL be round-robin among non-empty FIFOs.
- Search starts at the channel after the last granted one.
- The pointer advances only on a load.
REQ-023 Minimum latency SHALL be 1 cycle: an edge detected in cycle N appears with ev_valid=1 in cycle N+1 if the slot is free and the channel wins the grant.
REQ-024 Back-to-back operation SHALL sustain one event per cycle while ev_ready=1 and any FIFO is non-empty.
REQ-025 Drain/push collisions: a push and a pop on the same FIFO in one cycle SHALL both take effect; the count is unchanged.

Reset
REQ-026 On rst=1, asynchronously:
- all prev = x (11);
- all FIFOs empty;
- RR pointer = channel NCH-1, so channel 0 has first priority;
- ev_valid=0, ev_chan=0, ev_neg=0;
- ovf=0.
REQ-027 Reset asserted mid-operation SHALL discard all pending and presented events; the first post-reset detection compares against x.

Verification
REQ-028 Run ch0 through the sequence x,0,1,0,z,x,1,x, one value per cycle, with ev_ready=1. Required output order on ch0: neg, pos, neg, pos, pos, neg. Totals: 3 pos, 3 neg; z->x emits nothing.
REQ-029 Hold ev_ready=0 and toggle ch1 0/1 for 6 cycles. Required response:
- 4 edges fill the FIFO;
- ev_valid and the slot contents stay stable;
- ovf[1]=1 after the overflowing edge.
- ovf_clr[1] then clears it.
REQ-030 Make simultaneous 0->1 edges on ch0..ch3 with ev_ready=1. Required output: ev_chan 0,1,2,3 on consecutive cycles, each with ev_neg=0.
REQ-031 Hold en=0 while sig changes, then assert en=1. Required response: no events while disabled; the first comparison is against the value held before disable.
REQ-032 Assert rst for one cycle while ev_valid=1 with FIFOs non-empty. Required response:
- ev_valid drops immediately;
- no stale events after release;
- a 0 on ch0 next cycle yields exactly one negedge.
